// File: rtl/puzzle_fetch_seq_if.sv
// Sequencer <-> ROM / execute-stage bus for the 8-puzzle solver core.
interface puzzle_fetch_seq_if #(
  parameter int PC_W = 6,
  parameter int OP_W = 16
);
  logic [PC_W-1:0] pc;
  logic [OP_W-1:0] op;
  logic [OP_W-1:0] ex_op;
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_done;
  logic            ex_flag;
  logic            ex_flag_we;

  // Sequencer side: owns pc and the issue half of the handshake.
  modport master (
    output pc, ex_op, ex_valid,
    input  op, ex_ready, ex_done, ex_flag, ex_flag_we
  );

  // ROM / execute side.
  modport slave (
    input  pc, ex_op, ex_valid,
    output op, ex_ready, ex_done, ex_flag, ex_flag_we
  );
endinterface

// File: rtl/puzzle_fetch_seq.sv
// Program sequencer: fetches from a combinational ROM, resolves JMP/JNZ
// locally, hands all other ops to execute and waits for completion.
// A branch onto its own address is the program's terminal loop -> HALT.
module puzzle_fetch_seq #(
  parameter int              PC_W     = 6,
  parameter int              OP_W     = 16,
  parameter logic [4:0]      JMP_OP   = 5'd1,
  parameter logic [4:0]      JNZ_OP   = 5'd2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                restart,
  puzzle_fetch_seq_if.master  bus,
  output logic                flag,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT
  } state_t;

  state_t          state, nstate;
  logic [OP_W-1:0] ir;
  logic [PC_W-1:0] pc;
  logic [4:0]      opc;
  logic [PC_W-1:0] target;
  logic            is_jmp, is_jnz, take;
  logic            accept, complete, branch;

  assign opc    = ir[OP_W-1 -: 5];
  assign target = ir[PC_W-1:0];
  assign is_jmp = (opc == JMP_OP);
  assign is_jnz = (opc == JNZ_OP);
  // JMP always goes to target; JNZ only when the flag is set.
  assign take   = is_jmp || (is_jnz && flag);

  // Completion may land on the accept cycle itself (ISSUE) or later (WAIT).
  assign accept   = (state == S_ISSUE) && bus.ex_ready;
  assign complete = (accept && bus.ex_done) || ((state == S_WAIT) && bus.ex_done);
  assign branch   = (state == S_DECODE) && (is_jmp || is_jnz);

  assign bus.pc = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next-state logic; restart overrides everything and re-enters FETCH.
  always_comb begin
    nstate = state;
    if (restart) nstate = S_FETCH;
    else begin
      case (state)
        S_IDLE:   if (start) nstate = S_FETCH;
        S_FETCH:  nstate = S_DECODE;
        S_DECODE: begin
          if (is_jmp || is_jnz)
            nstate = (take && (target == pc)) ? S_HALT : S_FETCH;
          else
            nstate = S_ISSUE;
        end
        S_ISSUE:  if (bus.ex_ready) nstate = bus.ex_done ? S_FETCH : S_WAIT;
        S_WAIT:   if (bus.ex_done) nstate = S_FETCH;
        S_HALT:   nstate = S_HALT;
        default:  nstate = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state alone, so reset drops them asynchronously.
  always_comb begin
    bus.ex_valid = 1'b0;
    bus.ex_op    = '0;
    busy         = 1'b1;
    halted       = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_HALT:  begin busy = 1'b0; halted = 1'b1; end
      S_ISSUE: begin bus.ex_valid = 1'b1; bus.ex_op = ir; end
      default: ;
    endcase
  end

  // Datapath: instruction register, pc, flag and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      flag    <= 1'b0;
      retired <= '0;
    end else if (restart) begin
      pc      <= RESET_PC;
      ir      <= '0;
      flag    <= 1'b0;
      retired <= '0;
    end else begin
      if (state == S_FETCH) ir <= bus.op;
      // A self-target keeps pc as is, which is what HALT needs.
      if (branch) pc <= take ? target : pc + PC_W'(1);
      if (complete) begin
        if (bus.ex_flag_we) flag <= bus.ex_flag;
        pc <= pc + PC_W'(1);
      end
      if ((complete || branch) && (retired != 16'hFFFF))
        retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_puzzle_fetch_seq.sv
// Directed bench for puzzle_fetch_seq with a behavioural ROM and a
// hand-driven execute stage.
module tb_puzzle_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, restart;
  logic        flag, busy, halted;
  logic [15:0] retired;
  logic [15:0] rom [64];
  int          checks = 0;
  int          errors = 0;
  int          xfers  = 0;

  puzzle_fetch_seq_if #(.PC_W(6), .OP_W(16)) bus ();

  puzzle_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .restart(restart),
    .bus(bus), .flag(flag), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  assign bus.op = rom[bus.pc];

  always @(posedge clk) if (bus.ex_valid && bus.ex_ready) xfers <= xfers + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for ISSUE; returns the number of cycles waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.ex_valid !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  // Run one non-branch op through execute. stall = cycles of ex_ready=0,
  // same = ex_done on the accept cycle.
  task automatic do_ex(input string tag, input logic [15:0] eop, input logic [5:0] epc,
                       input int stall, input bit same, input bit fl, input bit we);
    int n, x0;
    logic [5:0] npc;
    npc = epc + 6'd1;
    ex_clear();
    wait_valid(n);
    chk({tag, " valid"}, bus.ex_valid, 1);
    chk({tag, " op"}, bus.ex_op, eop);
    if (same) chk({tag, " latency"}, n, 2);
    x0 = xfers;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " stall valid"}, bus.ex_valid, 1);
      chk({tag, " stall op"}, bus.ex_op, eop);
      chk({tag, " stall pc"}, bus.pc, epc);
    end
    bus.ex_ready = 1'b1;
    if (same) begin bus.ex_done = 1'b1; bus.ex_flag = fl; bus.ex_flag_we = we; end
    tick();
    bus.ex_ready = 1'b0;
    if (!same) begin
      chk({tag, " wait valid"}, bus.ex_valid, 0);
      chk({tag, " wait pc"}, bus.pc, epc);
      bus.ex_done = 1'b1; bus.ex_flag = fl; bus.ex_flag_we = we;
      tick();
    end
    ex_clear();
    chk({tag, " xfers"}, xfers - x0, 1);
    chk({tag, " next pc"}, bus.pc, npc);
  endtask

  task automatic ex_clear();
    bus.ex_ready = 1'b0; bus.ex_done = 1'b0; bus.ex_flag = 1'b0; bus.ex_flag_we = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h3A01;  rom[1]  = 16'hC123;  rom[2]  = 16'h5555;
    rom[3]  = 16'h100D;  // JNZ -> 13
    rom[4]  = 16'h6004;
    rom[5]  = 16'h082B;  // JMP -> 43
    rom[13] = 16'h7013;
    rom[14] = 16'h1010;  // JNZ -> 16
    rom[16] = 16'h0800;  // JMP -> 0
    rom[43] = 16'h082B;  // JMP -> 43 (terminal)
    rom[63] = 16'h9F3F;
    rst_n = 1'b0; start = 1'b0; restart = 1'b0;
    ex_clear();
    #12;
    chk("rst pc", bus.pc, 0);
    chk("rst ex_valid", bus.ex_valid, 0);
    chk("rst ex_op", bus.ex_op, 0);
    chk("rst busy", busy, 0);
    chk("rst halted", halted, 0);
    chk("rst flag", flag, 0);
    chk("rst retired", retired, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("start busy", busy, 1);
    chk("start pc", bus.pc, 0);

    // Straight line 0..2, last op writes flag=1.
    do_ex("sl0", 16'h3A01, 6'd0, 0, 0, 0, 0);
    do_ex("sl1", 16'hC123, 6'd1, 0, 0, 0, 0);
    do_ex("sl2", 16'h5555, 6'd2, 0, 0, 1, 1);
    chk("sl retired", retired, 3);
    chk("sl flag", flag, 1);

    // JNZ taken; a stray ex_done in FETCH/DECODE must not touch the flag.
    bus.ex_done = 1'b1; bus.ex_flag = 1'b0; bus.ex_flag_we = 1'b1;
    tick();
    chk("jnz1 decode valid", bus.ex_valid, 0);
    tick();
    ex_clear();
    chk("jnz1 pc", bus.pc, 13);
    chk("jnz1 flag", flag, 1);
    chk("jnz1 retired", retired, 4);

    // Non-writing op keeps flag, following JNZ taken, then JMP -> 0.
    do_ex("nowe", 16'h7013, 6'd13, 0, 0, 0, 0);
    chk("nowe flag", flag, 1);
    tick(); chk("jnz2 valid", bus.ex_valid, 0);
    tick(); chk("jnz2 pc", bus.pc, 16);
    tick(); chk("jmp valid", bus.ex_valid, 0);
    tick(); chk("jmp pc", bus.pc, 0);
    chk("jmp retired", retired, 7);

    // Second pass: clear flag, backpressure on op1.
    do_ex("clr", 16'h3A01, 6'd0, 0, 0, 0, 1);
    chk("clr flag", flag, 0);
    do_ex("bp", 16'hC123, 6'd1, 3, 0, 0, 0);
    do_ex("sl2b", 16'h5555, 6'd2, 0, 0, 1, 0);
    tick(); chk("jnz nt valid", bus.ex_valid, 0);
    tick(); chk("jnz nt pc", bus.pc, 4);
    chk("jnz nt retired", retired, 11);
    do_ex("same", 16'h6004, 6'd4, 0, 1, 0, 0);
    chk("same retired", retired, 12);
    tick(); tick();
    chk("jmp43 pc", bus.pc, 43);
    chk("jmp43 retired", retired, 13);

    // Terminal self-jump.
    tick(); tick();
    chk("halt halted", halted, 1);
    chk("halt busy", busy, 0);
    chk("halt pc", bus.pc, 43);
    start = 1'b1; bus.ex_done = 1'b1; bus.ex_flag = 1'b1; bus.ex_flag_we = 1'b1;
    tick();
    start = 1'b0; ex_clear();
    tick();
    chk("halt hold", halted, 1);
    chk("halt hold pc", bus.pc, 43);
    chk("halt flag", flag, 0);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart pc", bus.pc, 0);
    chk("restart busy", busy, 1);
    chk("restart halted", halted, 0);
    chk("restart retired", retired, 0);

    // Restart in WAIT with a coincident ex_done.
    do_ex("ab0", 16'h3A01, 6'd0, 0, 0, 1, 1);
    wait_valid(n);
    chk("ab valid", bus.ex_valid, 1);
    bus.ex_ready = 1'b1; tick(); bus.ex_ready = 1'b0;
    chk("ab wait", bus.ex_valid, 0);
    restart = 1'b1; bus.ex_done = 1'b1; bus.ex_flag = 1'b1; bus.ex_flag_we = 1'b1;
    tick();
    restart = 1'b0; ex_clear();
    chk("ab flag", flag, 0);
    chk("ab retired", retired, 0);
    chk("ab pc", bus.pc, 0);
    chk("ab ex_valid", bus.ex_valid, 0);

    // pc wrap 63 -> 0.
    rom[0] = 16'h083F;  // JMP -> 63
    tick(); tick();
    rom[0] = 16'h3A01;
    chk("wrap pc63", bus.pc, 63);
    do_ex("wrap", 16'h9F3F, 6'd63, 0, 0, 0, 0);
    chk("wrap retired", retired, 2);

    // Asynchronous reset mid-ISSUE.
    wait_valid(n);
    chk("arst pre valid", bus.ex_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", bus.ex_valid, 0);
    chk("arst ex_op", bus.ex_op, 0);
    chk("arst busy", busy, 0);
    #1 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puzzle_fetch_seq.md
Name: puzzle_fetch_seq

Overview:
- Program sequencer for the 8-puzzle solver core.
- Drives the 6-bit pc into the combinational instruction ROM and latches the returned 16-bit op into an instruction register.
- Resolves JMP/JNZ locally using a flag produced by the execute stage.
- Hands every other instruction to the execute stage over a valid/ready handshake, then waits for a completion pulse.
- Detects the terminal self-jump (WAIT loop) and reports halt.

Parameters:
- PC_W, 6, program counter width.
- OP_W, 16, instruction width.
- JMP_OP, 5'd1, opcode value of JMP in op[15:11]; must equal the JMP value in def.h.
- JNZ_OP, 5'd2, opcode value of JNZ in op[15:11]; must equal the JNZ value in def.h.
- RESET_PC, 0, pc value after reset or restart.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE
- restart  in  1  synchronous abort; highest priority after reset
- pc  out  PC_W  address to the instruction ROM
- op  in  OP_W  ROM data, combinational from pc
- ex_op  out  OP_W  instruction presented to execute
- ex_valid  out  1  ex_op is valid
- ex_ready  in  1  execute accepts ex_op
- ex_done  in  1  one-cycle completion pulse from execute
- ex_flag  in  1  result flag (nonzero/match) of the completed instruction
- ex_flag_we  in  1  with ex_done: update the flag register
- flag  out  1  current flag register
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- retired  out  16  count of completed instructions (branches included), saturating at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous) sets the following, and the state is IDLE:
  - pc=RESET_PC, ir=0, flag=0, retired=0
  - ex_valid=0, ex_op=0, busy=0, halted=0
- restart (synchronous, any state) has the same effect as reset, except that the next state is FETCH and busy=1 next cycle. Any pending or accepted ex transaction is dropped. An ex_done arriving in the same cycle is ignored.
- States:
  - IDLE: wait for start, then go to FETCH.
  - FETCH: pc is stable. At the clock edge, ir<=op and go to DECODE. This gives 1 cycle of ROM latency.
  - DECODE: opc=ir[15:11], target=ir[5:0].
    - opc==JMP_OP: if target==pc, go to HALT with pc unchanged. Otherwise pc<=target and go to FETCH.
    - opc==JNZ_OP: if flag==1, pc<=target (if target==pc, go to HALT), else pc<=pc+1; then go to FETCH.
    - Both branch cases: retired increments.
    - Any other opcode: go to ISSUE.
  - ISSUE: ex_valid=1 and ex_op=ir, both held stable until ex_ready.
    - On ex_valid&&ex_ready, go to WAIT.
    - If ex_done is also high in that same cycle, complete immediately: perform the WAIT completion actions and go to FETCH.
  - WAIT: ex_valid=0.
    - On ex_done: if ex_flag_we then flag<=ex_flag; pc<=pc+1; retired++; go to FETCH.
  - HALT: all outputs hold. Only restart or reset leaves this state; start is ignored.
- ex_done is ignored in IDLE, FETCH, DECODE and HALT (no flag or pc change).
- The flag changes only on an accepted ex_done with ex_flag_we. Branches never modify it.
- pc+1 wraps 63->0 modulo 2^PC_W. There is no halt on wrap.
- start while busy is ignored.
- Latency:
  - Taken/not-taken branch: 2 cycles (FETCH+DECODE).
  - Non-branch with ex_ready=1 and done on the accept cycle: 3 cycles.
- retired saturates at 16'hFFFF and does not wrap.

Test Plan:
- Straight line: ROM holds non-branch ops at 0..2; ex_ready=1, ex_done 1 cycle after accept. Required: ex_op equals ROM[0],ROM[1],ROM[2] in order; pc sequences 0,1,2,3; retired=3.
- Branch: ROM[3]=JNZ->13.
  - flag=1: next pc=13.
  - flag=0: next pc=4.
  - ROM[16]=JMP->0: pc=0 two cycles after FETCH of 16.
  - In all three cases ex_valid never rises for the branch.
- Flag write: complete an op with ex_flag=1, ex_flag_we=1; then an op with ex_flag=0, ex_flag_we=0. Required: flag stays 1, and a following JNZ is taken.
- Backpressure: hold ex_ready=0 for 3 cycles in ISSUE. Required: ex_valid=1 and ex_op stable all 3 cycles; exactly one transfer; pc advances only after ex_done.
- Halt: ROM[43]=JMP->43. Required: halted=1, busy=0, pc=43 held; start ignored; restart returns pc=0, busy=1, halted=0 next cycle.
- Abort/wrap:
  - restart asserted in WAIT, with ex_done in the same cycle: required flag and retired=0, pc=0, ex_valid=0.
  - Non-branch at pc=63 completes: required pc=0.
  - rst_n pulsed low mid-ISSUE: required ex_valid drops asynchronously.
